key_sched_ctrl: RTL and testbench
=================================

# key_sched_ctrl

AES-128 key-schedule controller. It loads a 128-bit cipher key and drives the existing single-round key-expansion datapath `gen_sub` once per clock for 10 rounds. It stores all 11 round keys in a local register file and serves them by index to the encrypt/decrypt round engines. It sits between the SD-card key register and the cipher core; decryption reads the keys in reverse index order.

## Interface
- `NUM_ROUNDS`, 10: number of expansion rounds; round keys are indexed 0..NUM_ROUNDS.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `key_load`  in  1  single-cycle start strobe; samples `key_in`.
- `key_in`  in  128  cipher key; word w0 = [127:96], w3 = [31:0].
- `rk_rd_idx`  in  4  round-key index to read, 0..10.
- `rk_out`  out  128  registered round key for the `rk_rd_idx` presented on the previous cycle.
- `busy`  out  1  high while expansion is in progress.
- `keys_ready`  out  1  high when all 11 round keys are valid.

## Operation
- **FSM states:** IDLE, EXPAND, DONE.
  - IDLE + `key_load`: write `key_in` to rk[0], round counter := 1, go to EXPAND.
  - EXPAND: each cycle drives `gen_sub` with `data_in` = rk[cnt-1] and `rcon` = {RC[cnt], 24'h0}, then writes `data_out` to rk[cnt].
    - If cnt == 10: go to DONE.
    - Otherwise: cnt := cnt+1.
  - DONE + `key_load`: overwrite rk[0], cnt := 1, go to EXPAND. This is a re-key.
- **RC table (cnt 1..10):** 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex).
- **`key_load` in EXPAND:** ignored. No restart and no corruption of the expansion in progress.
- **Output flags:**
  - `busy` = (state == EXPAND).
  - `keys_ready` = (state == DONE).
  - `keys_ready` drops in the cycle after a re-key `key_load` is accepted.
- **Read port:**
  - `rk_out` <= rk[`rk_rd_idx`] every cycle, regardless of state.
  - `rk_rd_idx` > 10 gives `rk_out` <= 128'h0.
  - Consumers must treat data as valid only while `keys_ready` is high.
- **Reset** (any time, including mid-EXPAND):
  - state = IDLE, cnt = 0.
  - All rk[0..10] = 0.
  - `rk_out` = 0, `busy` = 0, `keys_ready` = 0.

## Timing
- `key_load` sampled at edge T0. Results by edge:
  - T0: rk[0] is written.
  - T1..T10: rk[1]..rk[10] are written, one per edge.
  - `busy` is high from after T0 through T10.
  - `keys_ready` is high from after T10.
- Total latency from `key_load` to `keys_ready` is 10 cycles.
- The `gen_sub` path is purely combinational, so the critical path is one `gen_sub` plus the register-file write mux. There is no multicycle path.
- Read latency is 1 cycle: an index applied before edge N appears on `rk_out` after edge N.
- Reading an index while it is being written returns the old value.
- No back-pressure: once started, expansion always completes unless reset.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_NUM_ROUNDS` = 10.
  - 10-entry RC byte constant array.
  - `key_sched_state_t` enum (IDLE, EXPAND, DONE).
  - `round_key_t` typedef (logic [127:0]).
- Sub-module: instantiate the existing `gen_sub` unchanged, exactly once. Write no separate RC module; the RC lookup is a package-constant index.
- The register file is 11 × `round_key_t` flops inside this block. The counter is 4 bits.

## Test plan
- **Reset value check:** assert `n_rst` low mid-run -> `busy` = 0, `keys_ready` = 0, `rk_out` = 0. After release, any `rk_rd_idx` returns 0.
- **FIPS-197 vector:** `key_load` with `key_in` = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - `keys_ready` rises exactly 10 cycles later.
  - rk[0] equals `key_in`.
  - rk[1] = a0fafe17 88542cb1 23a33939 2a6c7605.
  - rk[10] = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- **Load ignored in EXPAND:** pulse `key_load` with key 0 at cycle 4 of EXPAND -> ignored; rk[10] still equals d014f9a8… and `keys_ready` still rises at cycle 10.
- **Re-key from DONE:** from DONE, `key_load` with all-zero key.
  - `keys_ready` falls the next cycle.
  - After 10 cycles, rk[1] = 62636363 62636363 62636363 62636363.
  - rk[10] = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- **Reverse-order read:** sweep `rk_rd_idx` 10 down to 0 -> each key appears one cycle after its index. Index 11 and index 15 return 0.
- **Reset mid-expansion:** assert reset at cycle 5 of EXPAND -> IDLE and all keys 0. Then a fresh `key_load` completes normally in 10 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key-schedule controller and its consumers.
package aes_pkg;

    localparam int AES_NUM_ROUNDS = 10;

    // Round constants for expansion rounds 1..10, stored at index round-1.
    localparam logic [7:0] AES_RC [0:AES_NUM_ROUNDS-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } key_sched_state_t;

    typedef logic [127:0] round_key_t;

endpackage

// File: rtl/gen_sub.sv
// Single combinational AES-128 key-expansion round: rk[n-1] + rcon -> rk[n].
module gen_sub (
    input  logic [127:0] data_in,
    input  logic [31:0]  rcon,
    output logic [127:0] data_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, with 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        r = gf_mul(r, r);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, temp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = data_in;
    assign rot  = {w3[23:0], w3[31:24]};
    assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ rcon;
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;
    assign data_out = {n0, n1, n2, n3};

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule controller: expands a loaded key one round per clock
// into an 11-entry round-key file and serves keys by index with 1-cycle latency.
//
// state  | meaning
// IDLE   | no key loaded since reset
// EXPAND | writing rk[cnt] from rk[cnt-1] each cycle
// DONE   | all round keys valid; key_load starts a re-key
module key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         keys_ready
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    key_sched_state_t state;
    logic [3:0]       cnt;
    round_key_t       rk [0:NUM_ROUNDS];
    logic [3:0]       prev_idx;
    round_key_t       prev_key;
    logic [31:0]      rcon;
    round_key_t       next_key;

    // cnt is only 0 outside of EXPAND; clamp so the lookups stay in range.
    assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    assign prev_key = rk[prev_idx];
    assign rcon     = {AES_RC[prev_idx], 24'h0};

    gen_sub u_gen_sub (
        .data_in  (prev_key),
        .rcon     (rcon),
        .data_out (next_key)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rk_out     <= '0;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk[i] <= '0;
            end
        end else begin
            if (rk_rd_idx <= LAST_IDX) rk_out <= rk[rk_rd_idx];
            else                       rk_out <= '0;

            case (state)
                IDLE, DONE: begin
                    if (key_load) begin
                        rk[0]      <= key_in;
                        cnt        <= 4'd1;
                        state      <= EXPAND;
                        busy       <= 1'b1;
                        keys_ready <= 1'b0;
                    end
                end
                EXPAND: begin
                    rk[cnt] <= next_key;
                    if (cnt == LAST_IDX) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    keys_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl against a whole-schedule reference model.
module tb_key_sched_ctrl;

    logic         clk;
    logic         n_rst;
    logic         key_load;
    logic [127:0] key_in;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_out;
    logic         busy;
    logic         keys_ready;

    int checks   = 0;
    int failures = 0;

    key_sched_ctrl dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .key_load   (key_load),
        .key_in     (key_in),
        .rk_rd_idx  (rk_rd_idx),
        .rk_out     (rk_out),
        .busy       (busy),
        .keys_ready (keys_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]   sb [0:255];
    logic [127:0] m_sched [0:10];
    logic [127:0] m_rk [0:10];
    logic [127:0] m_out;
    logic         m_exp;
    logic         m_ready;
    int           m_cnt;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // S-box generated by walking generator 3 and its inverse simultaneously.
    function automatic void build_sbox();
        logic [7:0] p, q, x;
        int guard;
        p = 8'h01;
        q = 8'h01;
        guard = 0;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
            guard++;
        end while (p != 8'h01 && guard < 300);
        sb[0] = 8'h63;
    endfunction

    function automatic void expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = key;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i <= 10; i++) m_rk[i] = '0;
        m_out   = '0;
        m_exp   = 1'b0;
        m_ready = 1'b0;
        m_cnt   = 0;
    endfunction

    // One rising edge of the specified behaviour.
    function automatic void model_edge(input logic ld, input logic [127:0] k, input logic [3:0] idx);
        logic [127:0] nxt_out;
        nxt_out = (idx <= 4'd10) ? m_rk[idx] : '0;
        if (!m_exp && ld) begin
            expand(k);
            m_rk[0] = k;
            m_cnt   = 1;
            m_exp   = 1'b1;
            m_ready = 1'b0;
        end else if (m_exp) begin
            m_rk[m_cnt] = m_sched[m_cnt];
            if (m_cnt == 10) begin
                m_exp   = 1'b0;
                m_ready = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        m_out = nxt_out;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk("busy", {127'b0, busy}, {127'b0, m_exp});
        chk("keys_ready", {127'b0, keys_ready}, {127'b0, m_ready});
        chk("rk_out", rk_out, m_out);
    endtask

    // Called at a falling edge: drive, take one rising edge, compare at next falling edge.
    task automatic step(input logic ld, input logic [127:0] k, input logic [3:0] idx);
        key_load  = ld;
        key_in    = k;
        rk_rd_idx = idx;
        @(posedge clk);
        model_edge(ld, k, idx);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        key_load = 1'b0;
        n_rst    = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        n_rst = 1'b1;
        step(1'b0, '0, 4'd0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!keys_ready && n < 20) begin
            step(1'b0, '0, 4'd0);
            n++;
        end
    endtask

    int n;

    initial begin
        n_rst     = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        rk_rd_idx = 4'd0;
        build_sbox();
        model_reset();
        @(negedge clk);
        do_reset();

        // model pins against published vectors
        expand(FIPS_KEY);
        chk("model_fips_rk10", m_sched[10], FIPS_RK10);
        expand('0);
        chk("model_zero_rk1", m_sched[1], ZERO_RK1);

        // FIPS-197 key
        step(1'b1, FIPS_KEY, 4'd0);
        wait_ready(n);
        chk("fips_latency", 128'(n), 128'd10);
        step(1'b0, '0, 4'd0);
        chk("fips_rk0", rk_out, FIPS_KEY);
        step(1'b0, '0, 4'd1);
        chk("fips_rk1", rk_out, FIPS_RK1);
        step(1'b0, '0, 4'd10);
        chk("fips_rk10", rk_out, FIPS_RK10);

        // load during expansion is ignored
        step(1'b1, FIPS_KEY, 4'd0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 4'd0);
        step(1'b1, '0, 4'd0);
        wait_ready(n);
        chk("ignored_load_latency", 128'(n + 4), 128'd10);
        step(1'b0, '0, 4'd10);
        chk("ignored_load_rk10", rk_out, FIPS_RK10);

        // reverse-order sweep
        for (int i = 10; i >= 0; i--) step(1'b0, '0, 4'(i));
        chk("sweep_rk0", rk_out, FIPS_KEY);
        step(1'b0, '0, 4'd11);
        chk("idx11_zero", rk_out, '0);
        step(1'b0, '0, 4'd15);
        chk("idx15_zero", rk_out, '0);

        // re-key from DONE with all-zero key
        step(1'b1, '0, 4'd0);
        chk("rekey_ready_drop", {127'b0, keys_ready}, '0);
        wait_ready(n);
        chk("rekey_latency", 128'(n), 128'd10);
        step(1'b0, '0, 4'd1);
        chk("zero_rk1", rk_out, ZERO_RK1);
        step(1'b0, '0, 4'd10);
        chk("zero_rk10", rk_out, ZERO_RK10);

        // reset in the middle of expansion
        step(1'b1, FIPS_KEY, 4'd0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 4'd3);
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            step(1'b0, '0, 4'(i));
            chk("rst_mid_rk_zero", rk_out, '0);
        end
        step(1'b1, FIPS_KEY, 4'd0);
        wait_ready(n);
        chk("post_reset_latency", 128'(n), 128'd10);
        step(1'b0, '0, 4'd10);
        chk("post_reset_rk10", rk_out, FIPS_RK10);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 7) == 0),
                     {$urandom, $urandom, $urandom, $urandom},
                     4'($urandom_range(0, 15)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
